multi_channel_debouncer: RTL

Parametrised N-channel button/switch debouncer that succeeds the single-channel early-detection debouncer. Each channel independently runs early (react-then-lockout) or late (wait-for-stable) detection, chosen per channel at elaboration, and handles both press and release. Each channel has a 2-flop input synchronizer, a registered debounced level and single-cycle rise/fall pulses. Sits between raw board inputs and control logic such as counters and menu FSMs.

---
 rtl/debounce_pkg.sv | 8 +
 rtl/debounce_channel.sv | 66 ++++++
 rtl/multi_channel_debouncer.sv | 29 ++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM state type and counter sizing for the debouncer channels
package debounce_pkg;
    typedef enum logic [1:0] {LOW, PEND_HI, HIGH, PEND_LO} deb_state_t;

    function automatic int cnt_width(input int hold);
        return (hold < 2) ? 1 : $clog2(hold);
    endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one synchronised input, early or late debounce FSM, registered level and edge pulses
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int HOLD_CYCLES = 2_000_000,
    parameter bit EARLY       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = cnt_width(HOLD_CYCLES);

    logic [1:0]    sync_q;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d, rise_q, fall_q;
    logic          sync, expired, pend;

    assign sync    = sync_q[1];
    assign expired = cnt_q == CW'(HOLD_CYCLES - 1);
    assign pend    = state_q == PEND_HI || state_q == PEND_LO;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    // Early mode ignores the input while pending; late mode aborts on disagreement
    always_comb begin
        state_d = LOW;
        case (state_q)
            LOW:     state_d = sync ? PEND_HI : LOW;
            PEND_HI: state_d = (!EARLY && !sync) ? LOW : expired ? HIGH : PEND_HI;
            HIGH:    state_d = sync ? HIGH : PEND_LO;
            PEND_LO: state_d = (!EARLY && sync) ? HIGH : expired ? LOW : PEND_LO;
            default: state_d = LOW;
        endcase
    end

    always_comb begin
        level_d = EARLY ? (state_d == PEND_HI || state_d == HIGH)
                        : (state_d == HIGH || state_d == PEND_LO);
        cnt_d   = (pend && state_d == state_q) ? cnt_q + CW'(1) : '0;
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer: N independent debounce channels, mode chosen per channel by EARLY_MASK
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              HOLD_CYCLES = 2_000_000,
    parameter logic [N_CH-1:0] EARLY_MASK  = '1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
);
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        debounce_channel #(
            .HOLD_CYCLES(HOLD_CYCLES),
            .EARLY      (EARLY_MASK[k])
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .btn_i  (btn_i[k]),
            .level_o(level_o[k]),
            .rise_o (rise_o[k]),
            .fall_o (fall_o[k])
        );
    end
endmodule
